seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Command-driven controller that sequences one instance of the team's serial sequence detector. It accepts a scan command containing a pattern, a hit target and a bit budget. It loads the pattern into the detector, flushes the detector history, then forwards the serial stream and counts qualified detector hits. It returns a single response: target reached, or budget exhausted, or aborted.

Parameters:
N, 3, pattern width; must match the detector's N
HW, 4, width of hit target/hit count
LW, 8, width of bit budget/bit count
DET_LAT, 1, cycles from a bit presented on det_a to det_valid reflecting it (1..4)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_seq  in  N  pattern to scan for
cmd_hits  in  HW  hit target; 0 = count until budget ends
cmd_len  in  LW  bit budget; 0 = rejected (immediate response)
abort  in  1  terminate current scan
bit_in  in  1  serial stream, one bit per clk
det_a  out  1  serial bit to detector
det_seq  out  N  pattern to detector
det_reset_n  out  1  detector reset (active-low)
det_valid  in  1  detector match flag
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  response consumer ready
rsp_hit  out  1  hit target reached
rsp_abort  out  1  scan ended by abort
rsp_count  out  HW  qualified hits counted
rsp_bits  out  LW  bits consumed

Behaviour:
- Reset: state IDLE; cmd_ready=1, det_reset_n=0, det_seq=0, det_a=0, rsp_valid=0, rsp_hit=0, rsp_abort=0, rsp_count=0, rsp_bits=0, all counters 0.
- det_a is bit_in registered (one-cycle delay). det_seq is registered and changes only on command accept.
- States: IDLE, FLUSH, RUN, RESP.
- IDLE: cmd_valid&&cmd_ready accepts the command and latches seq/hits/len; det_seq<=cmd_seq.
  - cmd_len==0: go to RESP with count=0, bits=0, hit=0.
  - Otherwise: go to FLUSH.
- IDLE holds det_reset_n=0.
- FLUSH: exactly 1 cycle with det_reset_n=0, then RUN; bit_count=0, hit_count=0.
- RUN: det_reset_n=1; each cycle bit_count+=1 (bit consumed = det_a of that cycle).
  - A hit is qualified when det_valid=1 and the bit that produced it is at least the Nth bit since FLUSH.
  - Qualification uses a DET_LAT-deep shift of the "bit_count>=N-1 at presentation" flag, aligned with det_valid.
  - Overlapping matches count individually (e.g. 000 on stream 0000 = 2 hits).
- RUN exit, evaluated each cycle in this priority:
  1. abort: RESP with rsp_abort=1.
  2. Target reached: cmd_hits!=0 and hit_count reaches cmd_hits. RESP with rsp_hit=1.
  3. Budget spent: bit_count reaches cmd_len and DET_LAT drain cycles have elapsed. RESP with hit=0. Hits arriving during drain still count and can still set rsp_hit.
- Budget-spent case with cmd_hits==0: rsp_hit=0.
- hit_count saturates at 2^HW-1. bit_count never exceeds cmd_len.
- RESP: rsp_valid=1 and all rsp_* fields stable until rsp_valid&&rsp_ready; next cycle IDLE.
  - rsp_bits = bits forwarded excluding drain cycles.
  - abort is ignored outside RUN.
  - det_reset_n returns to 0 on entering RESP.
- cmd_ready=0 in FLUSH/RUN/RESP. A command offered then waits; it is not dropped.
- Response acceptance and new-command acceptance cannot share a cycle; there is minimum 1 IDLE cycle between them.
- reset in any state returns to the reset values next edge; an in-flight scan is discarded with no response.

Decomposition:
- Package seq_scan_pkg: state enum (IDLE, FLUSH, RUN, RESP); response struct {hit, abort, count, bits}; localparam of max DET_LAT=4.
- One natural sub-module: seq_scan_qual, the DET_LAT-deep qualification shift register plus saturating hit counter.
- The detector itself stays external, connected by the top level.

Test Plan:
- Reset mid-RUN (cmd 010, hits=2, len=20; assert reset at bit 5) -> next cycle IDLE, cmd_ready=1, rsp_valid=0, det_reset_n=0, no response ever issued.
- cmd seq=000, hits=0, len=6, stream 0,0,0,0,0,1 -> rsp_count=3 (overlapping), rsp_hit=0, rsp_bits=6; no hit credited on bits 1-2.
- cmd seq=010, hits=2, len=20, alternating stream starting 0 -> rsp_hit=1, rsp_count=2 after 5 bits, rsp_bits=5.
- cmd seq=111, hits=1, len=8, all-zero stream -> rsp_hit=0, rsp_count=0, rsp_bits=8; response held 3 cycles with rsp_ready=0, fields unchanged.
- cmd len=0 -> rsp_valid two cycles after accept, count=0, bits=0, no FLUSH (det_reset_n stays 0).
- abort asserted at RUN bit 4 together with a completing hit (seq 000, hits=1) -> rsp_abort=1, rsp_hit=0; a queued command is accepted only after rsp handshake plus one IDLE cycle.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the sequence-scan controller and its hit qualifier.
// The response struct widths fix the controller's HW/LW parameters.
package seq_scan_pkg;

  localparam int unsigned MaxDetLat = 4;
  localparam int unsigned DrainW    = $clog2(MaxDetLat + 1);

  localparam int unsigned PatW = 3;
  localparam int unsigned HitW = 4;
  localparam int unsigned LenW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFlush,
    StRun,
    StResp
  } scan_state_e;

  typedef struct packed {
    logic            hit;
    logic            abort;
    logic [HitW-1:0] count;
    logic [LenW-1:0] bits;
  } scan_rsp_t;

  function automatic scan_rsp_t make_rsp(input logic            hit,
                                         input logic            abort,
                                         input logic [HitW-1:0] count,
                                         input logic [LenW-1:0] bits);
    scan_rsp_t r;
    r.hit   = hit;
    r.abort = abort;
    r.count = count;
    r.bits  = bits;
    return r;
  endfunction

endpackage

// File: rtl/seq_scan_qual.sv
// Hit qualifier: delays the "enough history" flag to line up with det_valid, then keeps a
// saturating count of the detector hits that survive qualification.
module seq_scan_qual #(
  parameter int unsigned HW      = 4,
  parameter int unsigned DET_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          count_en,
  input  logic          flag,
  input  logic          det_valid,
  output logic [HW-1:0] hit_count,
  output logic [HW-1:0] hit_next
);

  logic [DET_LAT-1:0] flag_pipe;
  logic               hit_qual;

  if (DET_LAT == 1) begin : g_pipe_one
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        flag_pipe <= '0;
      end else begin
        flag_pipe <= flag;
      end
    end
  end else begin : g_pipe_deep
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        flag_pipe <= '0;
      end else begin
        flag_pipe <= {flag_pipe[DET_LAT-2:0], flag};
      end
    end
  end

  assign hit_qual = det_valid && flag_pipe[DET_LAT-1];

  // Saturate instead of wrapping so a long budget never under-reports.
  assign hit_next = (count_en && hit_qual && (hit_count != '1)) ? hit_count + HW'(1)
                                                                : hit_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hit_count <= '0;
    end else begin
      hit_count <= hit_next;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Command-driven controller that loads, flushes and feeds an external serial sequence detector,
// counting qualified hits until the target, the bit budget or an abort ends the scan.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned N       = PatW,
  parameter int unsigned HW      = HitW,
  parameter int unsigned LW      = LenW,
  parameter int unsigned DET_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_seq,
  input  logic [HW-1:0] cmd_hits,
  input  logic [LW-1:0] cmd_len,
  input  logic          abort,
  input  logic          bit_in,
  output logic          det_a,
  output logic [N-1:0]  det_seq,
  output logic          det_reset_n,
  input  logic          det_valid,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic          rsp_abort,
  output logic [HW-1:0] rsp_count,
  output logic [LW-1:0] rsp_bits
);

  scan_state_e       state_q;
  logic [HW-1:0]     hits_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     bit_count_q;
  logic [DrainW-1:0] drain_q;
  scan_rsp_t         rsp_q;

  logic          in_run;
  logic          consuming;
  logic          qual_flag;
  logic          target_hit;
  logic          drain_done;
  logic [HW-1:0] hit_count;
  logic [HW-1:0] hit_next;

  assign in_run    = (state_q == StRun);
  assign consuming = (bit_count_q < len_q);
  // A hit only counts if the bit that produced it had N-1 real bits before it.
  assign qual_flag = in_run && consuming && (bit_count_q >= LW'(N - 1));

  assign target_hit = (hits_q != '0) && (hit_next == hits_q);
  assign drain_done = !consuming && (drain_q == DrainW'(DET_LAT - 1));

  seq_scan_qual #(
    .HW      (HW),
    .DET_LAT (DET_LAT)
  ) u_qual (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == StFlush),
    .count_en  (in_run),
    .flag      (qual_flag),
    .det_valid (det_valid),
    .hit_count (hit_count),
    .hit_next  (hit_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_ready   <= 1'b1;
      det_reset_n <= 1'b0;
      det_seq     <= '0;
      det_a       <= 1'b0;
      hits_q      <= '0;
      len_q       <= '0;
      bit_count_q <= '0;
      drain_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_q       <= '0;
    end else begin
      det_a <= bit_in;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            det_seq   <= cmd_seq;
            hits_q    <= cmd_hits;
            len_q     <= cmd_len;
            if (cmd_len == '0) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_q     <= make_rsp(1'b0, 1'b0, '0, '0);
            end else begin
              state_q <= StFlush;
            end
          end
        end

        StFlush: begin
          bit_count_q <= '0;
          drain_q     <= '0;
          det_reset_n <= 1'b1;
          state_q     <= StRun;
        end

        StRun: begin
          if (abort) begin
            state_q     <= StResp;
            det_reset_n <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_q       <= make_rsp(1'b0, 1'b1, hit_next, bit_count_q);
          end else if (target_hit) begin
            state_q     <= StResp;
            det_reset_n <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_q       <= make_rsp(1'b1, 1'b0, hit_next, bit_count_q);
          end else if (!consuming) begin
            // Budget spent: wait out the detector latency so late hits are still seen.
            if (drain_done) begin
              state_q     <= StResp;
              det_reset_n <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_q       <= make_rsp(1'b0, 1'b0, hit_next, bit_count_q);
            end else begin
              drain_q <= drain_q + DrainW'(1);
            end
          end else begin
            bit_count_q <= bit_count_q + LW'(1);
          end
        end

        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rsp_hit   = rsp_q.hit;
  assign rsp_abort = rsp_q.abort;
  assign rsp_count = rsp_q.count;
  assign rsp_bits  = rsp_q.bits;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: a behavioural 1-cycle serial detector, a table of scans with
// hand-computed responses, and directed sequences for reset, hold, len=0 and abort.
module tb_seq_scan_ctrl;

  localparam int unsigned N       = 3;
  localparam int unsigned HW      = 4;
  localparam int unsigned LW      = 8;
  localparam int unsigned DET_LAT = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_seq;
  logic [HW-1:0] cmd_hits;
  logic [LW-1:0] cmd_len;
  logic          abort;
  logic          bit_in;
  logic          det_a;
  logic [N-1:0]  det_seq;
  logic          det_reset_n;
  logic          det_valid = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic          rsp_abort;
  logic [HW-1:0] rsp_count;
  logic [LW-1:0] rsp_bits;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(
    .N       (N),
    .HW      (HW),
    .LW      (LW),
    .DET_LAT (DET_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_seq     (cmd_seq),
    .cmd_hits    (cmd_hits),
    .cmd_len     (cmd_len),
    .abort       (abort),
    .bit_in      (bit_in),
    .det_a       (det_a),
    .det_seq     (det_seq),
    .det_reset_n (det_reset_n),
    .det_valid   (det_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_hit     (rsp_hit),
    .rsp_abort   (rsp_abort),
    .rsp_count   (rsp_count),
    .rsp_bits    (rsp_bits)
  );

  // Detector model: MSB of the pattern is the oldest bit; overlapping matches allowed.
  logic [N-1:0] hist = '0;
  always @(posedge clk) begin
    if (!det_reset_n) begin
      hist      <= '0;
      det_valid <= 1'b0;
    end else begin
      hist      <= {hist[N-2:0], det_a};
      det_valid <= ({hist[N-2:0], det_a} == det_seq);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] s, input logic [HW-1:0] h, input logic [LW-1:0] l);
    int w;
    w         = 0;
    cmd_seq   = s;
    cmd_hits  = h;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    check("cmd_ready before accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Called one cycle after accept; drives stream bit k so it reaches det_a in RUN cycle k.
  task automatic stream_until_rsp(input logic [63:0] stream, input int abort_at);
    int cnt;
    cnt    = 0;
    bit_in = stream[0];
    while (rsp_valid !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
      bit_in = (cnt < 64) ? stream[cnt] : 1'b0;
      abort  = (cnt - 1 == abort_at);
    end
    abort  = 1'b0;
    bit_in = 1'b0;
    check("rsp_valid within cycle bound", rsp_valid, 1);
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("idle cmd_ready after handshake", cmd_ready, 1);
    check("rsp_valid low after handshake", rsp_valid, 0);
  endtask

  typedef struct {
    string         name;
    logic [N-1:0]  seq;
    logic [HW-1:0] hits;
    logic [LW-1:0] len;
    logic [63:0]   stream;
    logic          e_hit;
    logic [HW-1:0] e_count;
    logic [LW-1:0] e_bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int seen;
    int waited;

    vecs[0] = '{"overlap000", 3'b000, 4'd0, 8'd6,  64'h20,               1'b0, 4'd3,  8'd6};
    vecs[1] = '{"target010",  3'b010, 4'd2, 8'd20, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 4'd2, 8'd5};
    vecs[2] = '{"target101",  3'b101, 4'd3, 8'd12, 64'h5555_5555_5555_5555, 1'b1, 4'd3, 8'd7};
    vecs[3] = '{"drainhit",   3'b011, 4'd1, 8'd3,  64'h6,                1'b1, 4'd1,  8'd3};
    vecs[4] = '{"saturate",   3'b000, 4'd0, 8'd30, 64'h0,                1'b0, 4'd15, 8'd30};
    vecs[5] = '{"len0",       3'b110, 4'd5, 8'd0,  64'h0,                1'b0, 4'd0,  8'd0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_seq   = '0;
    cmd_hits  = '0;
    cmd_len   = '0;
    abort     = 1'b0;
    bit_in    = 1'b1;
    rsp_ready = 1'b0;
    repeat (3) step();
    check("reset cmd_ready", cmd_ready, 1);
    check("reset det_reset_n", det_reset_n, 0);
    check("reset det_seq", det_seq, 0);
    check("reset det_a", det_a, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_count", rsp_count, 0);
    check("reset rsp_bits", rsp_bits, 0);
    reset  = 1'b0;
    bit_in = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].seq, vecs[i].hits, vecs[i].len);
      stream_until_rsp(vecs[i].stream, -1);
      check({vecs[i].name, " rsp_hit"}, rsp_hit, vecs[i].e_hit);
      check({vecs[i].name, " rsp_abort"}, rsp_abort, 0);
      check({vecs[i].name, " rsp_count"}, rsp_count, vecs[i].e_count);
      check({vecs[i].name, " rsp_bits"}, rsp_bits, vecs[i].e_bits);
      finish_rsp();
    end

    // len=0: immediate response, detector never released from reset.
    issue(3'b101, 4'd1, 8'd0);
    waited = 0;
    while (rsp_valid !== 1'b1 && waited < 2) begin
      check("len0 det_reset_n held", det_reset_n, 0);
      step();
      waited++;
    end
    check("len0 rsp_valid latency", rsp_valid, 1);
    check("len0 det_reset_n", det_reset_n, 0);
    check("len0 rsp_count", rsp_count, 0);
    check("len0 rsp_bits", rsp_bits, 0);
    finish_rsp();

    // Response held with rsp_ready low.
    issue(3'b111, 4'd1, 8'd8);
    stream_until_rsp(64'h0, -1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold rsp_valid", rsp_valid, 1);
      check("hold rsp_hit", rsp_hit, 0);
      check("hold rsp_count", rsp_count, 0);
      check("hold rsp_bits", rsp_bits, 8);
      check("hold det_reset_n", det_reset_n, 0);
    end
    finish_rsp();

    // Abort in the same RUN cycle as the hit that would meet the target.
    issue(3'b000, 4'd1, 8'd20);
    stream_until_rsp(64'h1, 4);
    check("abort rsp_abort", rsp_abort, 1);
    check("abort rsp_hit", rsp_hit, 0);
    check("abort rsp_bits", rsp_bits, 4);
    cmd_seq   = 3'b111;
    cmd_hits  = 4'd0;
    cmd_len   = 8'd2;
    cmd_valid = 1'b1;
    step();
    check("queued cmd_ready in RESP", cmd_ready, 0);
    check("queued rsp_valid held", rsp_valid, 1);
    finish_rsp();
    step();
    check("queued cmd taken", cmd_ready, 0);
    cmd_valid = 1'b0;
    stream_until_rsp(64'h0, -1);
    check("queued rsp_bits", rsp_bits, 2);
    check("queued rsp_abort", rsp_abort, 0);
    finish_rsp();

    // Reset in the middle of RUN discards the scan.
    issue(3'b010, 4'd2, 8'd20);
    bit_in = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrun reset cmd_ready", cmd_ready, 1);
    check("midrun reset rsp_valid", rsp_valid, 0);
    check("midrun reset det_reset_n", det_reset_n, 0);
    check("midrun reset det_seq", det_seq, 0);
    seen = 0;
    repeat (10) begin
      step();
      if (rsp_valid === 1'b1) seen = 1;
    end
    check("midrun reset no response", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
